mpq_param: RTL and testbench
============================

// Module: mpq_param
// PURPOSE
//  Parametrised heap-based priority queue. Loads an initial array, then executes one command at a time:
//  build, extract, increase, decrease, insert, clear and write-back to external RAM.
//  Generalises the 8-bit/256-entry max queue: data width, depth and ordering (max/min) are configurable.
//  Adds decrease-key, clear, an error flag and an extracted-value output port.
// PARAMETERS
//  DW        8    data/key width in bits
//  DEPTH     256  heap capacity in entries (>=2)
//  AW        $clog2(DEPTH)  index width (derived, not overridable)
//  MAX_HEAP  1    1 = max-heap (larger value wins); 0 = min-heap (smaller value wins)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      synchronous, active-high reset
//  data_valid  in   1      load-phase data strobe
//  data        in   DW     load-phase data, appended at index size
//  cmd_valid   in   1      command strobe; sampled only when busy==0
//  cmd         in   3      command code (see BEHAVIOUR)
//  index       in   AW     target index for INCREASE/DECREASE
//  value       in   DW     new key for INCREASE/DECREASE/INSERT
//  busy        out  1      1 = commands ignored
//  RAM_valid   out  1      write strobe to external RAM
//  RAM_A       out  AW     RAM write address
//  RAM_D       out  DW     RAM write data
//  done        out  1      one-cycle pulse when WRITE completes
//  top_valid   out  1      one-cycle pulse: top_data holds the value removed by EXTRACT
//  top_data    out  DW     extracted value (held until the next EXTRACT)
//  err         out  1      one-cycle pulse: command or load beat rejected, heap unchanged
// BEHAVIOUR
//  Reset: busy=1; RAM_valid, RAM_A, RAM_D, done, top_valid, top_data and err are 0; size=0; state=LOAD.
//  Reset mid-command aborts the command and discards heap contents.
//  "better(a,b)": a>b when MAX_HEAP=1, a<b when MAX_HEAP=0; unsigned compare. Ties never swap.
//  States:
//   LOAD: each cycle with data_valid=1 stores data at heap[size] and increments size.
//    A beat arriving when size==DEPTH is dropped and pulses err.
//    The first cycle with data_valid=0 -> IDLE; busy falls on the next edge.
//   IDLE: busy=0. cmd_valid=1 latches cmd/index/value, sets busy=1 on the next edge, then dispatches.
//   SIFT_DN: compares node i with children l=2i+1 and r=2i+2 (only those < size).
//    Swaps with the better child (l on tie); at most one swap per cycle.
//    Ends when no child is better than node i.
//   SIFT_UP: while i>0 and better(heap[i],heap[(i-1)>>1]): swap, i=parent. One level per cycle.
//   WR: streams heap[0..size-1] out on RAM_valid/RAM_A/RAM_D, one entry per cycle, RAM_A = entry index.
//    Cycle after the last entry: RAM_valid=0, done=1 for one cycle.
//   FIN: one cycle; clears busy and returns to IDLE. Every command ends via FIN.
//  Commands:
//   000 BUILD: for i = size/2-1 down to 0, run SIFT_DN(i). size<=1 completes with no change.
//   001 EXTRACT: top_data=heap[0] and top_valid=1; heap[0]=heap[size-1]; size--; then SIFT_DN(0).
//    size==0 -> err, no top_valid.
//   010 INCREASE: moves a key toward the top.
//    index>=size -> err.
//    value not better than heap[index] (including equal) -> no change, no err.
//    Otherwise heap[index]=value, then SIFT_UP(index).
//   011 INSERT: size==DEPTH -> err. Otherwise heap[size]=value; size++; SIFT_UP(old size).
//   100 WRITE: enter WR; size==0 gives done with no RAM_valid beats.
//   101 DECREASE: moves a key away from the top; mirror of INCREASE.
//    value not worse than heap[index] -> no change.
//    Otherwise heap[index]=value, then SIFT_DN(index).
//   110 CLEAR: size=0; heap storage not cleared.
//   111 reserved -> err.
//  err is asserted for exactly one cycle, in the dispatch cycle.
//  A rejected command still passes through FIN, so busy is high for 2 cycles.
//  Index arithmetic: l/r are computed at AW+1 bits so 2i+2 never wraps; a child >= size does not exist.
//  size is AW+1 bits (0..DEPTH).
//  cmd_valid while busy=1 is ignored (not queued). data_valid outside LOAD is ignored.
//  Latency: INSERT/INCREASE <= 2+log2(DEPTH) cycles; WRITE = size+3 cycles from accept to busy=0.
// STRUCTURE
//  mpq_pkg: command codes (CMD_BUILD..CMD_CLEAR), state enum (LOAD, IDLE, DISPATCH, SIFT_DN, SIFT_UP,
//   WR, FIN), better() function taking MAX_HEAP.
//  Sub-module mpq_sift_sel: combinational child/parent select.
//   Inputs: i, size, heap[i], heap[l], heap[r], heap[parent].
//   Outputs: swap_dn, dn_idx, swap_up.
//  Heap storage is a flat register array inside mpq_param; single sift engine shared by all commands.
// TESTING
//  1. MAX_HEAP=1, DW=8: load 3,1,4,1,5,9,2,6; BUILD; WRITE -> RAM gets 9,6,4,1,5,3,2,1; done once.
//  2. After test 1: EXTRACT -> top_data=9; WRITE -> 6,5,4,1,1,3,2.
//  3. INSERT 10 -> root 10; INCREASE idx6 to 0 -> no change, no err; DECREASE idx0 to 0 -> 0 sinks to a leaf.
//  4. DEPTH=4: load 4 values then a 5th beat -> err pulse; INSERT -> err; size stays 4.
//  5. EXTRACT on empty heap -> err, no top_valid. INCREASE index>=size -> err. cmd 111 -> err.
//  6. MAX_HEAP=0, DW=16: load 500,20,300,7; BUILD; WRITE -> RAM[0]=7.
//     Assert rst during WR -> next cycle RAM_valid=0, busy=1, state LOAD.

Source files
------------

// File: rtl/mpq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mpq_pkg : command codes, FSM states and ordering helper for mpq_param
// Revision: 1.0
// ---------------------------------------------------------------------------
package mpq_pkg;

  localparam logic [2:0] CMD_BUILD    = 3'b000;
  localparam logic [2:0] CMD_EXTRACT  = 3'b001;
  localparam logic [2:0] CMD_INCREASE = 3'b010;
  localparam logic [2:0] CMD_INSERT   = 3'b011;
  localparam logic [2:0] CMD_WRITE    = 3'b100;
  localparam logic [2:0] CMD_DECREASE = 3'b101;
  localparam logic [2:0] CMD_CLEAR    = 3'b110;

  // Keys are zero-extended to this width before comparison.
  localparam int KEY_W = 64;

  typedef enum logic [2:0] {
    LOAD     = 3'd0,
    IDLE     = 3'd1,
    DISPATCH = 3'd2,
    SIFT_DN  = 3'd3,
    SIFT_UP  = 3'd4,
    WR       = 3'd5,
    FIN      = 3'd6
  } state_t;

  function automatic logic better(input logic max_heap,
                                  input logic [KEY_W-1:0] a,
                                  input logic [KEY_W-1:0] b);
    return max_heap ? (a > b) : (a < b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mpq_sift_sel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mpq_sift_sel : combinational child/parent selection for one sift step
// Revision: 1.0
// ---------------------------------------------------------------------------
module mpq_sift_sel
  import mpq_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter bit MAX_HEAP = 1'b1
) (
  input  logic [AW-1:0] i,
  input  logic [AW:0]   size,
  input  logic [DW-1:0] key_i,
  input  logic [DW-1:0] key_l,
  input  logic [DW-1:0] key_r,
  input  logic [DW-1:0] key_p,
  output logic          swap_dn,
  output logic [AW-1:0] dn_idx,
  output logic          swap_up
);

  logic [AW:0]   l;
  logic [AW+1:0] r;
  logic          has_l;
  logic          has_r;
  logic          l_wins;
  logic          r_wins;

  assign l      = {i, 1'b1};
  assign r      = {1'b0, l} + (AW+2)'(1);
  assign has_l  = l < size;
  assign has_r  = r < {1'b0, size};
  assign l_wins = has_l && better(MAX_HEAP, KEY_W'(key_l), KEY_W'(key_i));
  // r must strictly beat the current winner, so l keeps ties
  assign r_wins = has_r && (l_wins ? better(MAX_HEAP, KEY_W'(key_r), KEY_W'(key_l))
                                   : better(MAX_HEAP, KEY_W'(key_r), KEY_W'(key_i)));

  assign swap_dn = l_wins || r_wins;
  assign dn_idx  = r_wins ? r[AW-1:0] : l[AW-1:0];
  assign swap_up = (i != '0) && better(MAX_HEAP, KEY_W'(key_i), KEY_W'(key_p));

endmodule
`default_nettype wire

// File: rtl/mpq_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mpq_param : parametrised heap priority queue with RAM write-back
// Revision: 1.0
// ---------------------------------------------------------------------------
module mpq_param
  import mpq_pkg::*;
#(
  parameter int  DW       = 8,
  parameter int  DEPTH    = 256,
  parameter bit  MAX_HEAP = 1'b1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          data_valid,
  input  logic [DW-1:0] data,
  input  logic          cmd_valid,
  input  logic [2:0]    cmd,
  input  logic [AW-1:0] index,
  input  logic [DW-1:0] value,
  output logic          busy,
  output logic          RAM_valid,
  output logic [AW-1:0] RAM_A,
  output logic [DW-1:0] RAM_D,
  output logic          done,
  output logic          top_valid,
  output logic [DW-1:0] top_data,
  output logic          err
);

  localparam int          NSLOT = 1 << AW;
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);

  logic [DW-1:0] heap [NSLOT];
  logic [AW:0]   size;
  state_t        state;
  logic [AW-1:0] cur;
  logic [AW-1:0] build_root;
  logic          building;
  logic [AW:0]   wr_ptr;
  logic [2:0]    op;
  logic [AW-1:0] op_idx;
  logic [DW-1:0] op_val;

  logic [AW-1:0] l_idx;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] p_idx;
  logic [AW-1:0] last_idx;
  logic [DW-1:0] tgt_key;
  logic          idx_ok;
  logic          inc_ok;
  logic          dec_ok;
  logic          swap_dn;
  logic          swap_up;
  logic [AW-1:0] dn_idx;

  // Read addresses only; existence of children is decided in the selector.
  assign l_idx    = AW'({cur, 1'b1});
  assign r_idx    = l_idx + AW'(1);
  assign p_idx    = (cur - AW'(1)) >> 1;
  assign last_idx = size[AW-1:0] - AW'(1);
  assign tgt_key  = heap[op_idx];
  assign idx_ok   = {1'b0, op_idx} < size;
  assign inc_ok   = better(MAX_HEAP, KEY_W'(op_val), KEY_W'(tgt_key));
  assign dec_ok   = better(MAX_HEAP, KEY_W'(tgt_key), KEY_W'(op_val));

  mpq_sift_sel #(
    .DW       (DW),
    .AW       (AW),
    .MAX_HEAP (MAX_HEAP)
  ) u_sel (
    .i       (cur),
    .size    (size),
    .key_i   (heap[cur]),
    .key_l   (heap[l_idx]),
    .key_r   (heap[r_idx]),
    .key_p   (heap[p_idx]),
    .swap_dn (swap_dn),
    .dn_idx  (dn_idx),
    .swap_up (swap_up)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      busy       <= 1'b1;
      size       <= '0;
      RAM_valid  <= 1'b0;
      RAM_A      <= '0;
      RAM_D      <= '0;
      done       <= 1'b0;
      top_valid  <= 1'b0;
      top_data   <= '0;
      err        <= 1'b0;
      cur        <= '0;
      build_root <= '0;
      building   <= 1'b0;
      wr_ptr     <= '0;
      op         <= '0;
      op_idx     <= '0;
      op_val     <= '0;
    end else begin
      RAM_valid <= 1'b0;
      done      <= 1'b0;
      top_valid <= 1'b0;
      err       <= 1'b0;
      case (state)
        LOAD: begin
          if (data_valid) begin
            if (size == FULL) begin
              err <= 1'b1;
            end else begin
              heap[size[AW-1:0]] <= data;
              size               <= size + (AW+1)'(1);
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (cmd_valid) begin
            op     <= cmd;
            op_idx <= index;
            op_val <= value;
            busy   <= 1'b1;
            state  <= DISPATCH;
          end
        end
        DISPATCH: begin
          building <= 1'b0;
          state    <= FIN;
          case (op)
            CMD_BUILD: begin
              if (size > (AW+1)'(1)) begin
                cur        <= size[AW:1] - AW'(1);
                build_root <= size[AW:1] - AW'(1);
                building   <= 1'b1;
                state      <= SIFT_DN;
              end
            end
            CMD_EXTRACT: begin
              if (size == '0) begin
                err <= 1'b1;
              end else begin
                top_data  <= heap[0];
                top_valid <= 1'b1;
                heap[0]   <= heap[last_idx];
                size      <= size - (AW+1)'(1);
                cur       <= '0;
                state     <= SIFT_DN;
              end
            end
            CMD_INCREASE: begin
              if (!idx_ok) begin
                err <= 1'b1;
              end else if (inc_ok) begin
                heap[op_idx] <= op_val;
                cur          <= op_idx;
                state        <= SIFT_UP;
              end
            end
            CMD_INSERT: begin
              if (size == FULL) begin
                err <= 1'b1;
              end else begin
                heap[size[AW-1:0]] <= op_val;
                size               <= size + (AW+1)'(1);
                cur                <= size[AW-1:0];
                state              <= SIFT_UP;
              end
            end
            CMD_WRITE: begin
              wr_ptr <= '0;
              state  <= WR;
            end
            CMD_DECREASE: begin
              if (!idx_ok) begin
                err <= 1'b1;
              end else if (dec_ok) begin
                heap[op_idx] <= op_val;
                cur          <= op_idx;
                state        <= SIFT_DN;
              end
            end
            CMD_CLEAR: size <= '0;
            default:   err  <= 1'b1;
          endcase
        end
        SIFT_DN: begin
          if (swap_dn) begin
            heap[cur]    <= heap[dn_idx];
            heap[dn_idx] <= heap[cur];
            cur          <= dn_idx;
          end else if (building && build_root != '0) begin
            build_root <= build_root - AW'(1);
            cur        <= build_root - AW'(1);
          end else begin
            state <= FIN;
          end
        end
        SIFT_UP: begin
          // Reaching the root needs no further compare, saving a cycle.
          if (swap_up) begin
            heap[cur]   <= heap[p_idx];
            heap[p_idx] <= heap[cur];
            cur         <= p_idx;
            if (p_idx == '0) state <= FIN;
          end else begin
            state <= FIN;
          end
        end
        WR: begin
          if (wr_ptr < size) begin
            RAM_valid <= 1'b1;
            RAM_A     <= wr_ptr[AW-1:0];
            RAM_D     <= heap[wr_ptr[AW-1:0]];
            wr_ptr    <= wr_ptr + (AW+1)'(1);
          end else begin
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mpq_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mpq_param : directed self-checking bench for mpq_param (three configs)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mpq_param;
  import mpq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst   = 3'b111;
  logic [2:0]  dv    = 3'b000;
  logic [2:0]  cv    = 3'b000;
  logic [15:0] data  = '0;
  logic [15:0] value = '0;
  logic [2:0]  cmd   = '0;
  logic [7:0]  index = '0;
  int          sel   = 0;

  logic       busy_a, ramv_a, done_a, topv_a, err_a;
  logic [7:0] rama_a, ramd_a, topd_a;
  logic       busy_b, ramv_b, done_b, topv_b, err_b;
  logic [1:0] rama_b;
  logic [7:0] ramd_b, topd_b;
  logic        busy_c, ramv_c, done_c, topv_c, err_c;
  logic [2:0]  rama_c;
  logic [15:0] ramd_c, topd_c;

  mpq_param #(.DW(8), .DEPTH(256), .MAX_HEAP(1'b1)) u_a (
    .clk(clk), .rst(rst[0]), .data_valid(dv[0]), .data(data[7:0]),
    .cmd_valid(cv[0]), .cmd(cmd), .index(index), .value(value[7:0]),
    .busy(busy_a), .RAM_valid(ramv_a), .RAM_A(rama_a), .RAM_D(ramd_a),
    .done(done_a), .top_valid(topv_a), .top_data(topd_a), .err(err_a)
  );

  mpq_param #(.DW(8), .DEPTH(4), .MAX_HEAP(1'b1)) u_b (
    .clk(clk), .rst(rst[1]), .data_valid(dv[1]), .data(data[7:0]),
    .cmd_valid(cv[1]), .cmd(cmd), .index(index[1:0]), .value(value[7:0]),
    .busy(busy_b), .RAM_valid(ramv_b), .RAM_A(rama_b), .RAM_D(ramd_b),
    .done(done_b), .top_valid(topv_b), .top_data(topd_b), .err(err_b)
  );

  mpq_param #(.DW(16), .DEPTH(8), .MAX_HEAP(1'b0)) u_c (
    .clk(clk), .rst(rst[2]), .data_valid(dv[2]), .data(data),
    .cmd_valid(cv[2]), .cmd(cmd), .index(index[2:0]), .value(value),
    .busy(busy_c), .RAM_valid(ramv_c), .RAM_A(rama_c), .RAM_D(ramd_c),
    .done(done_c), .top_valid(topv_c), .top_data(topd_c), .err(err_c)
  );

  logic        m_busy, m_ramv, m_done, m_topv, m_err;
  logic [7:0]  m_rama;
  logic [15:0] m_ramd, m_topd;

  always_comb begin
    m_busy = busy_a; m_ramv = ramv_a; m_done = done_a; m_topv = topv_a; m_err = err_a;
    m_rama = rama_a; m_ramd = 16'(ramd_a); m_topd = 16'(topd_a);
    case (sel)
      1: begin
        m_busy = busy_b; m_ramv = ramv_b; m_done = done_b; m_topv = topv_b; m_err = err_b;
        m_rama = 8'(rama_b); m_ramd = 16'(ramd_b); m_topd = 16'(topd_b);
      end
      2: begin
        m_busy = busy_c; m_ramv = ramv_c; m_done = done_c; m_topv = topv_c; m_err = err_c;
        m_rama = 8'(rama_c); m_ramd = ramd_c; m_topd = topd_c;
      end
      default: ;
    endcase
  end

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc, n_err, n_topv, n_done;
  logic [15:0] got_d[$];
  logic [7:0]  got_a[$];
  logic [15:0] exp_q[$];
  logic [15:0] stim[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset release coincides with the first beat so the DUT is still in LOAD.
  task automatic load(input string tag);
    n_err = 0;
    foreach (stim[k]) begin
      rst[sel] = 1'b0; dv[sel] = 1'b1; data = stim[k];
      step();
      if (m_err) n_err++;
    end
    dv[sel] = 1'b0;
    cyc = 0;
    while (m_busy && cyc < 20) begin
      step(); cyc++;
    end
    check({tag, "_idle"}, 32'(m_busy), 0);
  endtask

  task automatic do_cmd(input string tag, input logic [2:0] c, input logic [7:0] idx,
                        input logic [15:0] val);
    cmd = c; index = idx; value = val; cv[sel] = 1'b1;
    step();
    cv[sel] = 1'b0;
    check({tag, "_busy"}, 32'(m_busy), 1);
    n_err = 0; n_topv = 0; n_done = 0; cyc = 0;
    got_d.delete(); got_a.delete();
    while (m_busy && cyc < 600) begin
      step(); cyc++;
      if (m_err)  n_err++;
      if (m_topv) n_topv++;
      if (m_done) n_done++;
      if (m_ramv) begin
        got_d.push_back(m_ramd);
        got_a.push_back(m_rama);
      end
    end
    check({tag, "_idle"}, 32'(m_busy), 0);
  endtask

  task automatic write_chk(input string tag);
    do_cmd(tag, CMD_WRITE, 8'd0, 16'd0);
    check({tag, "_done"}, 32'(n_done), 1);
    check({tag, "_lat"}, 32'(cyc), 32'(exp_q.size() + 3));
    check({tag, "_beats"}, 32'(got_d.size()), 32'(exp_q.size()));
    foreach (exp_q[k]) begin
      if (k < got_d.size()) begin
        check($sformatf("%s_d%0d", tag, k), 32'(got_d[k]), 32'(exp_q[k]));
        check($sformatf("%s_a%0d", tag, k), 32'(got_a[k]), 32'(k));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) step();

    sel = 0;
    check("rst_busy", 32'(m_busy), 1);
    check("rst_ramv", 32'(m_ramv), 0);
    check("rst_done", 32'(m_done), 0);
    check("rst_topv", 32'(m_topv), 0);
    check("rst_err",  32'(m_err), 0);
    check("rst_rama", 32'(m_rama), 0);
    check("rst_ramd", 32'(m_ramd), 0);
    check("rst_topd", 32'(m_topd), 0);

    // max-heap build and write-back
    stim = '{3, 1, 4, 1, 5, 9, 2, 6};
    load("a_load");
    check("a_load_err", 32'(n_err), 0);
    do_cmd("a_build", CMD_BUILD, 8'd0, 16'd0);
    check("a_build_err", 32'(n_err), 0);
    exp_q = '{9, 6, 4, 1, 5, 3, 2, 1};
    write_chk("t1");

    do_cmd("a_ext", CMD_EXTRACT, 8'd0, 16'd0);
    check("a_ext_topv", 32'(n_topv), 1);
    check("a_ext_topd", 32'(m_topd), 9);
    check("a_ext_err", 32'(n_err), 0);
    exp_q = '{6, 5, 4, 1, 1, 3, 2};
    write_chk("t2");

    do_cmd("a_ins", CMD_INSERT, 8'd0, 16'd10);
    check("a_ins_err", 32'(n_err), 0);
    check("a_ins_lat", 32'(cyc <= 10), 1);
    do_cmd("a_inc_noop", CMD_INCREASE, 8'd6, 16'd0);
    check("a_inc_noop_err", 32'(n_err), 0);
    check("a_inc_noop_lat", 32'(cyc), 2);
    dv[0] = 1'b1; data = 16'd99;
    step();
    dv[0] = 1'b0;
    exp_q = '{10, 6, 4, 5, 1, 3, 2, 1};
    write_chk("t3a");
    do_cmd("a_dec", CMD_DECREASE, 8'd0, 16'd0);
    check("a_dec_err", 32'(n_err), 0);
    exp_q = '{6, 5, 4, 1, 1, 3, 2, 0};
    write_chk("t3b");
    check("a_topd_held", 32'(m_topd), 9);

    // capacity limits on a 4-entry heap
    sel = 1;
    stim = '{10, 20, 30, 40, 50};
    load("b_load");
    check("b_overflow_err", 32'(n_err), 1);
    do_cmd("b_ins", CMD_INSERT, 8'd0, 16'd7);
    check("b_ins_err", 32'(n_err), 1);
    check("b_ins_lat", 32'(cyc), 2);
    exp_q = '{10, 20, 30, 40};
    write_chk("t4");

    // rejected commands on an empty heap
    do_cmd("b_clr", CMD_CLEAR, 8'd0, 16'd0);
    check("b_clr_err", 32'(n_err), 0);
    do_cmd("b_ext", CMD_EXTRACT, 8'd0, 16'd0);
    check("b_ext_err", 32'(n_err), 1);
    check("b_ext_topv", 32'(n_topv), 0);
    do_cmd("b_inc", CMD_INCREASE, 8'd0, 16'd99);
    check("b_inc_err", 32'(n_err), 1);
    do_cmd("b_rsv", 3'b111, 8'd0, 16'd0);
    check("b_rsv_err", 32'(n_err), 1);
    check("b_rsv_lat", 32'(cyc), 2);
    exp_q.delete();
    write_chk("t5");

    // min-heap, 16-bit keys
    sel = 2;
    stim = '{500, 20, 300, 7};
    load("c_load");
    do_cmd("c_build", CMD_BUILD, 8'd0, 16'd0);
    exp_q = '{7, 20, 300, 500};
    write_chk("t6");

    // reset while streaming
    cmd = CMD_WRITE; cv[2] = 1'b1;
    step();
    cv[2] = 1'b0;
    step();
    step();
    check("c_wr_beat", 32'(m_ramv), 1);
    rst[2] = 1'b1;
    step();
    check("c_rst_ramv", 32'(m_ramv), 0);
    check("c_rst_busy", 32'(m_busy), 1);
    stim = '{9};
    load("c_reload");
    exp_q = '{9};
    write_chk("t6r");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
